// File: rtl/cpu_pkg.sv
// Shared definitions for the trap arbiter: FSM states, cause-code width,
// default trap-value width and the interrupt cause-code formula.
package cpu_pkg;

    localparam int CAUSE_W      = 4;
    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2
    } state_e;

    // An interrupt's cause code is its source index followed by 2'b11.
    function automatic logic [CAUSE_W-1:0] irq_cause(input logic [1:0] idx);
        return {idx, 2'b11};
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Priority encoder producing both a one-hot grant and its index.
// MSB_FIRST=0 grants the lowest set bit, MSB_FIRST=1 the highest.
module prio_enc #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b0,
    parameter int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Walk the bits in priority order and keep the first one that is set.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid_o && req_i[MSB_FIRST ? (N - 1 - k) : k]) begin
                valid_o  = 1'b1;
                idx_o    = IDX_W'(MSB_FIRST ? (N - 1 - k) : k);
                onehot_o[MSB_FIRST ? (N - 1 - k) : k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trap_arbiter.sv
// Trap arbiter: picks one exception or interrupt, presents it as a held
// request until acknowledged, and tracks handler activity until mret.
// Exceptions (lowest index first) always beat interrupts (highest index
// first); interrupts are only taken in IDLE on an instruction boundary.
module trap_arbiter
    import cpu_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEFAULT,
    parameter int               N_EXC    = 5,
    parameter int               N_IRQ    = 3,
    parameter logic [N_IRQ-1:0] IRQ_EDGE = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_EXC-1:0]           exc_en,
    input  logic [N_EXC*CAUSE_W-1:0]   exc_code,
    input  logic [N_EXC*XLEN-1:0]      exc_val,
    input  logic [N_IRQ-1:0]           irq_lvl,
    input  logic [N_IRQ-1:0]           mie,
    input  logic                       mstatus_mie,
    input  logic                       retire,
    input  logic                       mret,
    input  logic                       trap_ack,
    output logic                       trap_req,
    output logic                       trap_is_irq,
    output logic [CAUSE_W-1:0]         trap_code,
    output logic [XLEN-1:0]            trap_val,
    output logic [N_IRQ-1:0]           irq_pending,
    output logic                       busy
);

    localparam int EXC_IDX_W = (N_EXC > 1) ? $clog2(N_EXC) : 1;
    localparam int IRQ_IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    state_e               state_q, state_d;
    logic                 is_irq_q, is_irq_d;
    logic [CAUSE_W-1:0]   code_q, code_d;
    logic [XLEN-1:0]      val_q, val_d;
    logic [N_IRQ-1:0]     prev_q;
    logic [N_IRQ-1:0]     edge_pend_q, edge_pend_d;

    logic [N_EXC-1:0]     exc_onehot;
    logic [EXC_IDX_W-1:0] exc_idx;
    logic                 exc_any;
    logic [N_IRQ-1:0]     irq_elig;
    logic [N_IRQ-1:0]     irq_onehot;
    logic [IRQ_IDX_W-1:0] irq_idx;
    logic                 irq_any;

    logic [CAUSE_W-1:0]   exc_cause;
    logic [XLEN-1:0]      exc_tval;
    logic                 exc_take;
    logic                 irq_take;

    // Lowest-index exception wins.
    prio_enc #(
        .N         (N_EXC),
        .MSB_FIRST (1'b0),
        .IDX_W     (EXC_IDX_W)
    ) u_exc_enc (
        .req_i    (exc_en),
        .onehot_o (exc_onehot),
        .idx_o    (exc_idx),
        .valid_o  (exc_any)
    );

    // Highest-index eligible interrupt wins.
    prio_enc #(
        .N         (N_IRQ),
        .MSB_FIRST (1'b1),
        .IDX_W     (IRQ_IDX_W)
    ) u_irq_enc (
        .req_i    (irq_elig),
        .onehot_o (irq_onehot),
        .idx_o    (irq_idx),
        .valid_o  (irq_any)
    );

    // mip view: level sources pass straight through, edge sources use the latched bit.
    always_comb begin
        for (int i = 0; i < N_IRQ; i++) begin
            irq_pending[i] = IRQ_EDGE[i] ? edge_pend_q[i] : irq_lvl[i];
        end
        irq_elig = irq_pending & mie;
    end

    // Select the winning exception's cause by index and its tval by one-hot AND-OR.
    always_comb begin
        exc_cause = exc_code[int'(exc_idx)*CAUSE_W +: CAUSE_W];
        exc_tval  = '0;
        for (int i = 0; i < N_EXC; i++) begin
            exc_tval = exc_tval | (exc_val[i*XLEN +: XLEN] & {XLEN{exc_onehot[i]}});
        end
    end

    // Capture decisions: exceptions are accepted outside REQ, interrupts only from IDLE.
    always_comb begin
        exc_take = exc_any && (state_q != REQ);
        irq_take = (state_q == IDLE) && !exc_any && irq_any && mstatus_mie && retire;
    end

    // Next-state and captured-field logic.
    always_comb begin
        state_d  = state_q;
        is_irq_d = is_irq_q;
        code_d   = code_q;
        val_d    = val_q;

        unique case (state_q)
            IDLE:    if (exc_any || irq_take) state_d = REQ;
            REQ:     if (trap_ack)            state_d = HANDLER;
            HANDLER: begin
                if (exc_any)                  state_d = REQ;
                else if (mret)                state_d = IDLE;
            end
            default:                          state_d = IDLE;
        endcase

        if (exc_take) begin
            is_irq_d = 1'b0;
            code_d   = exc_cause;
            val_d    = exc_tval;
        end else if (irq_take) begin
            is_irq_d = 1'b1;
            code_d   = irq_cause(2'(irq_idx));
            val_d    = '0;
        end
    end

    // Edge sources latch on a rising edge; a capture clears its bit unless a new edge arrives.
    always_comb begin
        edge_pend_d = ((edge_pend_q & ~(irq_take ? irq_onehot : '0))
                      | (irq_lvl & ~prev_q)) & IRQ_EDGE;
    end

    // State, captured trap fields and edge-detect history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            is_irq_q    <= 1'b0;
            code_q      <= '0;
            val_q       <= '0;
            prev_q      <= '0;
            edge_pend_q <= '0;
        end else begin
            state_q     <= state_d;
            is_irq_q    <= is_irq_d;
            code_q      <= code_d;
            val_q       <= val_d;
            prev_q      <= irq_lvl;
            edge_pend_q <= edge_pend_d;
        end
    end

    assign trap_req    = (state_q == REQ);
    assign busy        = (state_q == HANDLER);
    assign trap_is_irq = is_irq_q;
    assign trap_code   = code_q;
    assign trap_val    = val_q;

endmodule

// File: tb/tb_trap_arbiter.sv
module tb_trap_arbiter;

    localparam int XLEN  = 64;
    localparam int N_EXC = 5;
    localparam int N_IRQ = 3;
    localparam logic [N_IRQ-1:0] EDGE_MASK = 3'b010;

    logic                   clk;
    logic                   rst_n;
    logic [N_EXC-1:0]       exc_en;
    logic [N_EXC*4-1:0]     exc_code;
    logic [N_EXC*XLEN-1:0]  exc_val;
    logic [N_IRQ-1:0]       irq_lvl;
    logic [N_IRQ-1:0]       mie;
    logic                   mstatus_mie;
    logic                   retire;
    logic                   mret;
    logic                   trap_ack;
    logic                   trap_req;
    logic                   trap_is_irq;
    logic [3:0]             trap_code;
    logic [XLEN-1:0]        trap_val;
    logic [N_IRQ-1:0]       irq_pending;
    logic                   busy;

    trap_arbiter #(
        .XLEN     (XLEN),
        .N_EXC    (N_EXC),
        .N_IRQ    (N_IRQ),
        .IRQ_EDGE (EDGE_MASK)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .exc_en      (exc_en),
        .exc_code    (exc_code),
        .exc_val     (exc_val),
        .irq_lvl     (irq_lvl),
        .mie         (mie),
        .mstatus_mie (mstatus_mie),
        .retire      (retire),
        .mret        (mret),
        .trap_ack    (trap_ack),
        .trap_req    (trap_req),
        .trap_is_irq (trap_is_irq),
        .trap_code   (trap_code),
        .trap_val    (trap_val),
        .irq_pending (irq_pending),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        irq;
        logic [3:0]  code;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   m_mode;              // 0: waiting, 1: request outstanding, 2: in handler
    bit   m_epend [N_IRQ];
    bit   m_prev  [N_IRQ];

    function automatic logic [N_IRQ-1:0] model_pending();
        logic [N_IRQ-1:0] p;
        for (int i = 0; i < N_IRQ; i++)
            p[i] = EDGE_MASK[i] ? m_epend[i] : irq_lvl[i];
        return p;
    endfunction

    function automatic int lowest_exc();
        for (int j = 0; j < N_EXC; j++)
            if (exc_en[j]) return j;
        return -1;
    endfunction

    function automatic exp_t exc_entry(input int j);
        exp_t e;
        e.irq  = 1'b0;
        e.code = exc_code[4*j +: 4];
        e.val  = exc_val[XLEN*j +: XLEN];
        return e;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0;
            for (int i = 0; i < N_IRQ; i++) begin
                m_epend[i] = 0;
                m_prev[i]  = 0;
            end
        end else begin
            logic [N_IRQ-1:0] elig;
            int ej;
            int hi;
            int taken;
            elig  = model_pending() & mie;
            ej    = lowest_exc();
            taken = -1;
            if (m_mode == 0) begin
                if (ej >= 0) begin
                    exp_q.push_back(exc_entry(ej));
                    m_mode = 1;
                end else if (elig != 0 && mstatus_mie && retire) begin
                    exp_t e;
                    hi = 0;
                    for (int i = 0; i < N_IRQ; i++) if (elig[i]) hi = i;
                    e.irq  = 1'b1;
                    e.code = 4'(hi * 4 + 3);
                    e.val  = '0;
                    exp_q.push_back(e);
                    taken  = hi;
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (trap_ack) m_mode = 2;
            end else begin
                if (ej >= 0) begin
                    exp_q.push_back(exc_entry(ej));
                    m_mode = 1;
                end else if (mret) begin
                    m_mode = 0;
                end
            end
            for (int i = 0; i < N_IRQ; i++) begin
                if (EDGE_MASK[i]) begin
                    if (irq_lvl[i] && !m_prev[i]) m_epend[i] = 1;
                    else if (taken == i)          m_epend[i] = 0;
                end
                m_prev[i] = irq_lvl[i];
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic prev_req = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("trap_req_vs_model", 64'(trap_req), 64'(m_mode == 1));
            chk("busy_vs_model", 64'(busy), 64'(m_mode == 2));
            chk("irq_pending_vs_model", 64'(irq_pending), 64'(model_pending()));
            if (trap_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_pop: trap_req rose with code 0x%0h but no capture expected", trap_code);
                end else begin
                    cur = exp_q.pop_front();
                    chk("sb_is_irq", 64'(trap_is_irq), 64'(cur.irq));
                    chk("sb_code", 64'(trap_code), 64'(cur.code));
                    chk("sb_val", trap_val, cur.val);
                end
            end else if (trap_req) begin
                chk("hold_code", 64'(trap_code), 64'(cur.code));
                chk("hold_val", trap_val, cur.val);
                chk("hold_is_irq", 64'(trap_is_irq), 64'(cur.irq));
            end
        end
        prev_req <= trap_req;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exc(input int i, input logic [3:0] c, input logic [63:0] v);
        exc_code[4*i +: 4]       = c;
        exc_val[XLEN*i +: XLEN]  = v;
    endtask

    initial begin
        rst_n = 1'b1; exc_en = '0; exc_code = '0; exc_val = '0;
        irq_lvl = '0; mie = '0; mstatus_mie = 1'b0; retire = 1'b0;
        mret = 1'b0; trap_ack = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_trap_req", 64'(trap_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_code", 64'(trap_code), 64'd0);
        chk("rst_val", trap_val, 64'd0);
        chk("rst_is_irq", 64'(trap_is_irq), 64'd0);
        chk("rst_pending", 64'(irq_pending), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // lowest set exception wins
        exc_en = 5'b00110; set_exc(1, 4'd2, 64'h10); set_exc(2, 4'd5, 64'h20);
        step(); exc_en = '0;
        chk("a_req", 64'(trap_req), 64'd1);
        chk("a_code", 64'(trap_code), 64'd2);
        chk("a_val", trap_val, 64'h10);
        chk("a_is_irq", 64'(trap_is_irq), 64'd0);
        trap_ack = 1'b1; step(); trap_ack = 1'b0;
        chk("a_busy", 64'(busy), 64'd1);
        chk("a_req_drop", 64'(trap_req), 64'd0);
        mret = 1'b1; step(); mret = 1'b0;
        chk("a_mret_idle", 64'(busy), 64'd0);

        // level interrupt, gated by retire
        irq_lvl = 3'b100; mie = 3'b111; mstatus_mie = 1'b1; retire = 1'b0;
        step();
        chk("b_no_retire", 64'(trap_req), 64'd0);
        retire = 1'b1; step(); retire = 1'b0;
        chk("b_req", 64'(trap_req), 64'd1);
        chk("b_code", 64'(trap_code), 64'd11);
        chk("b_is_irq", 64'(trap_is_irq), 64'd1);
        chk("b_val", trap_val, 64'd0);
        trap_ack = 1'b1; step(); trap_ack = 1'b0;
        retire = 1'b1; step();
        chk("b_handler_masks_irq", 64'(trap_req), 64'd0);
        retire = 1'b0; mret = 1'b1; irq_lvl = '0; step(); mret = 1'b0;

        // exception beats a simultaneous interrupt, interrupt taken later
        exc_en = 5'b01000; set_exc(3, 4'd9, 64'h33); irq_lvl = 3'b100; retire = 1'b1;
        step(); exc_en = '0; retire = 1'b0;
        chk("c_code", 64'(trap_code), 64'd9);
        chk("c_is_irq", 64'(trap_is_irq), 64'd0);
        trap_ack = 1'b1; step(); trap_ack = 1'b0;
        mret = 1'b1; step(); mret = 1'b0;
        chk("c_idle_req", 64'(trap_req), 64'd0);
        chk("c_still_pending", 64'(irq_pending), 64'b100);
        retire = 1'b1; step(); retire = 1'b0;
        chk("c_irq_code", 64'(trap_code), 64'd11);
        chk("c_irq_flag", 64'(trap_is_irq), 64'd1);
        irq_lvl = '0; trap_ack = 1'b1; step(); trap_ack = 1'b0;
        mret = 1'b1; step(); mret = 1'b0;

        // edge source 1: one-cycle pulse latched until captured
        irq_lvl = 3'b010; step(); irq_lvl = '0; step();
        chk("d_latched", 64'(irq_pending), 64'b010);
        step();
        chk("d_held", 64'(irq_pending), 64'b010);
        retire = 1'b1; step(); retire = 1'b0;
        chk("d_code", 64'(trap_code), 64'd7);
        chk("d_cleared", 64'(irq_pending), 64'b000);
        trap_ack = 1'b1; step(); trap_ack = 1'b0;
        mret = 1'b1; step(); mret = 1'b0;

        // request held without ack; new exception ignored
        exc_en = 5'b00001; set_exc(0, 4'd4, 64'hAA);
        step(); exc_en = '0;
        step();
        exc_en = 5'b00100; set_exc(2, 4'd2, 64'hBB); step(); exc_en = '0;
        mret = 1'b1; step(); mret = 1'b0;
        step();
        chk("e_hold_code", 64'(trap_code), 64'd4);
        chk("e_hold_val", trap_val, 64'hAA);
        chk("e_hold_req", 64'(trap_req), 64'd1);
        trap_ack = 1'b1; step(); trap_ack = 1'b0;
        chk("e_busy", 64'(busy), 64'd1);
        mret = 1'b1; step(); mret = 1'b0;
        chk("e_idle", 64'(busy), 64'd0);

        // asynchronous reset in REQ, then capture on first edge after release
        exc_en = 5'b00001; set_exc(0, 4'd1, 64'h5);
        step(); exc_en = '0;
        @(negedge clk); #2 rst_n = 1'b0; #1;
        chk("f_async_req", 64'(trap_req), 64'd0);
        chk("f_async_busy", 64'(busy), 64'd0);
        chk("f_async_code", 64'(trap_code), 64'd0);
        chk("f_async_val", trap_val, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; exc_en = 5'b00001; set_exc(0, 4'd6, 64'h66);
        step(); exc_en = '0;
        chk("f_first_edge_req", 64'(trap_req), 64'd1);
        chk("f_first_edge_code", 64'(trap_code), 64'd6);
        trap_ack = 1'b1; step(); trap_ack = 1'b0;
        @(negedge clk); #2 rst_n = 1'b0; #1;
        chk("f_async_busy_h", 64'(busy), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            exc_en = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
            exc_code = 20'($urandom);
            for (int k = 0; k < (N_EXC * XLEN) / 32; k++) exc_val[32*k +: 32] = $urandom;
            for (int k = 0; k < N_IRQ; k++)
                if ($urandom_range(0, 3) == 0) irq_lvl[k] = ~irq_lvl[k];
            mie         = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            mstatus_mie = ($urandom_range(0, 3) != 0);
            retire      = 1'($urandom_range(0, 1));
            mret        = ($urandom_range(0, 4) == 0);
            trap_ack    = ($urandom_range(0, 2) == 0);
            step();
        end

        exc_en = '0; mstatus_mie = 1'b0; retire = 1'b0; mret = 1'b0; trap_ack = 1'b0;
        repeat (3) step();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
